// File: rtl/rgb_led_bargraph_pkg.sv
// Shared constants for the RGB LED bargraph frame controller: geometry, level range
// and the frame FSM encoding.
package rgb_led_bargraph_pkg;

  localparam int ROWS      = 16;
  localparam int COLS      = 16;
  localparam int PIXELS    = ROWS * COLS;
  localparam int LEVEL_MAX = 256;

  localparam logic [1:0] ST_FILL     = 2'd0;
  localparam logic [1:0] ST_SWAP     = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  // Requests above full brightness saturate rather than wrap.
  function automatic logic [8:0] clamp_level(input logic [8:0] target);
    return (target > 9'(LEVEL_MAX)) ? 9'(LEVEL_MAX) : target;
  endfunction

endpackage

// File: rtl/rgb_led_bargraph_level_fader.sv
// Global dimming fader: moves level one step toward the clamped target every
// FADE_DIV clock cycles.
module rgb_led_bargraph_level_fader
  import rgb_led_bargraph_pkg::*;
#(
  parameter int FADE_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] level_target,
  output logic [8:0] level
);

  localparam logic [15:0] DIV_RELOAD = 16'(FADE_DIV - 1);

  logic [15:0] div_q, div_d;
  logic [8:0]  level_q, level_d;
  logic [8:0]  target_c;

  always_comb begin
    target_c = clamp_level(level_target);
    div_d    = div_q - 16'd1;
    level_d  = level_q;
    if (div_q == 16'd0) begin
      div_d = DIV_RELOAD;
      if (level_q < target_c) begin
        level_d = level_q + 9'd1;
      end else if (level_q > target_c) begin
        level_d = level_q - 9'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= DIV_RELOAD;
      level_q <= 9'd0;
    end else begin
      div_q   <= div_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/rgb_led_bargraph_frame_ctrl.sv
// Double-buffered frame writer: streams 256 pixels into the back buffer, swaps on a
// well-formed frame end and waits for the driver to show it; dimming via the fader.
module rgb_led_bargraph_frame_ctrl
  import rgb_led_bargraph_pkg::*;
#(
  parameter int FADE_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       drv_wr,
  output logic [8:0] drv_wr_addr,
  output logic [7:0] drv_wr_data,
  output logic       drv_buffer_select,
  input  logic       drv_buffer_current,
  input  logic [8:0] level_target,
  output logic [8:0] level,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] dbg_state
);

  localparam logic [7:0] LAST_PIX = 8'(PIXELS - 1);

  // Handshake: a pixel transfers on a clk edge where s_valid && s_ready; s_ready is
  // high only in FILL and does not depend on s_valid.
  logic [1:0] state_q, state_d;
  logic [7:0] pix_cnt_q, pix_cnt_d;
  logic       sel_q, sel_d;
  logic       wr_q, wr_d;
  logic [8:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    sel_d     = sel_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (s_valid) begin
          wr_d      = 1'b1;
          addr_d    = {~sel_q, pix_cnt_q};
          data_d    = s_data;
          pix_cnt_d = pix_cnt_q + 8'd1;
          if ((pix_cnt_q == LAST_PIX) && s_last) begin
            state_d = ST_SWAP;
          end else if (s_last || (pix_cnt_q == LAST_PIX)) begin
            // Misplaced or missing end marker: the pixel is still written, frame dropped.
            err_d     = 1'b1;
            pix_cnt_d = 8'd0;
          end
        end
      end
      ST_SWAP: begin
        sel_d   = ~sel_q;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (drv_buffer_current == sel_q) begin
          done_d    = 1'b1;
          pix_cnt_d = 8'd0;
          state_d   = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FILL;
      pix_cnt_q <= 8'd0;
      sel_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 9'd0;
      data_q    <= 8'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      sel_q     <= sel_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign s_ready           = (state_q == ST_FILL);
  assign drv_wr            = wr_q;
  assign drv_wr_addr       = addr_q;
  assign drv_wr_data       = data_q;
  assign drv_buffer_select = sel_q;
  assign frame_done        = done_q;
  assign frame_err         = err_q;
  assign dbg_state         = state_q;

  rgb_led_bargraph_level_fader #(
    .FADE_DIV(FADE_DIV)
  ) u_fader (
    .clk         (clk),
    .rst         (rst),
    .level_target(level_target),
    .level       (level)
  );

endmodule
